// File: rtl/stride_rd_gen.sv
// Strided AXI read-address generator: issues req_num ARs at base + k*stride and counts returned R beats.
// Latency: first m_ar_valid the cycle after start is sampled; done pulses one cycle after the last burst drains.
// Backpressure: AR payload held while m_ar_ready=0; ARs throttled at 2^LOG_MAX_OUT outstanding bursts.
// Optional: define STRIDE_RD_GEN_ID_CHECK_EN to flag R beats whose ID differs from the latched cfg_id.
module stride_rd_gen #(
   parameter int ADDR_BITS       = 16,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int TID_WIDTH       = 8,
   parameter int DATA_WIDTH      = 8,
   parameter int LOG_MAX_OUT     = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ADDR_BITS-1:0]       base_addr,
   input  logic [ADDR_BITS-1:0]       stride,
   input  logic [15:0]                req_num,
   input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
   input  logic [TID_WIDTH-1:0]       cfg_id,
   output logic                       m_ar_valid,
   output logic [ADDR_BITS-1:0]       m_ar_addr,
   output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
   output logic [TID_WIDTH-1:0]       m_ar_id,
   input  logic                       m_ar_ready,
   input  logic                       m_r_valid,
   input  logic                       m_r_last,
   input  logic [DATA_WIDTH-1:0]      m_r_data,
   input  logic [TID_WIDTH-1:0]       m_r_id,
   output logic                       m_r_ready,
   output logic                       busy,
   output logic                       done,
   output logic [15:0]                beat_cnt,
   output logic                       error
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   localparam int OW = LOG_MAX_OUT + 1;
   localparam logic [OW-1:0] MAX_OUT = {1'b1, {LOG_MAX_OUT{1'b0}}};

   state_t                     state_q, state_d;
   logic [OW-1:0]              out_q, out_d;
   logic [15:0]                k_q, k_d;
   logic [15:0]                num_q, num_d;
   logic [ADDR_BITS-1:0]       addr_q, addr_d;
   logic [ADDR_BITS-1:0]       stride_q, stride_d;
   logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
   logic [TID_WIDTH-1:0]       id_q, id_d;
   logic [BURST_LEN_WIDTH-1:0] bidx_q, bidx_d;
   logic [15:0]                beat_cnt_q, beat_cnt_d;
   logic                       error_q, error_d;

   logic ar_vld, r_rdy, ar_hs, r_hs, r_last_hs, id_bad;
   logic unused_bits;

   assign ar_vld    = (state_q == S_ISSUE) && (out_q < MAX_OUT);
   assign r_rdy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign ar_hs     = ar_vld && m_ar_ready;
   assign r_hs      = m_r_valid && r_rdy;
   // A stray last beat with nothing outstanding is an error but must not underflow the counter.
   assign r_last_hs = r_hs && m_r_last && (out_q != '0);

`ifdef STRIDE_RD_GEN_ID_CHECK_EN
   assign id_bad      = r_hs && (m_r_id != id_q);
   assign unused_bits = ^m_r_data;
`else
   assign id_bad      = 1'b0;
   assign unused_bits = ^{m_r_data, m_r_id};
`endif

   // Next-state, address walk, outstanding tracking and R beat/error accounting.
   always_comb begin
      state_d    = state_q;
      out_d      = out_q;
      k_d        = k_q;
      num_d      = num_q;
      addr_d     = addr_q;
      stride_d   = stride_q;
      len_d      = len_q;
      id_d       = id_q;
      bidx_d     = bidx_q;
      beat_cnt_d = beat_cnt_q;
      error_d    = error_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d     = base_addr;
               stride_d   = stride;
               num_d      = req_num;
               len_d      = cfg_len;
               id_d       = cfg_id;
               k_d        = '0;
               out_d      = '0;
               bidx_d     = '0;
               beat_cnt_d = '0;
               error_d    = 1'b0;
               state_d    = (req_num == 16'd0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ar_hs) begin
               k_d    = k_q + 16'd1;
               addr_d = addr_q + stride_q;
               if ((k_q + 16'd1) == num_q) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_q == '0) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      // R handshakes only occur in ISSUE/DRAIN, so these never collide with the start latch.
      if (r_hs) begin
         if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
         bidx_d = m_r_last ? '0 : bidx_q + 1'b1;
         if ((out_q == '0) || (m_r_last != (bidx_q == len_q)) || id_bad) error_d = 1'b1;
      end

      case ({ar_hs, r_last_hs})
         2'b10:   out_d = out_q + 1'b1;
         2'b01:   out_d = out_q - 1'b1;
         default: ;
      endcase
   end

   // State register with synchronous reset; every flop clears so a reset abandons the sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         out_q      <= '0;
         k_q        <= '0;
         num_q      <= '0;
         addr_q     <= '0;
         stride_q   <= '0;
         len_q      <= '0;
         id_q       <= '0;
         bidx_q     <= '0;
         beat_cnt_q <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         k_q        <= k_d;
         num_q      <= num_d;
         addr_q     <= addr_d;
         stride_q   <= stride_d;
         len_q      <= len_d;
         id_q       <= id_d;
         bidx_q     <= bidx_d;
         beat_cnt_q <= beat_cnt_d;
         error_q    <= error_d;
      end
   end

   assign m_ar_valid = ar_vld;
   assign m_ar_addr  = addr_q;
   assign m_ar_len   = len_q;
   assign m_ar_id    = id_q;
   assign m_r_ready  = r_rdy;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign beat_cnt   = beat_cnt_q;
   assign error      = error_q;

endmodule

// File: tb/tb_stride_rd_gen.sv
// Testbench for stride_rd_gen: directed sequences, AR scoreboard, behavioural AXI read slave.
// Latency: checks first AR valid one cycle after start and done after drain.
// Backpressure: optional AR ready toggling and withheld R data.
module tb_stride_rd_gen;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] base_addr, stride, req_num;
   logic [7:0]  cfg_len, cfg_id;
   logic        m_ar_valid, m_ar_ready;
   logic [15:0] m_ar_addr;
   logic [7:0]  m_ar_len, m_ar_id;
   logic        m_r_valid, m_r_last, m_r_ready;
   logic [7:0]  m_r_data, m_r_id;
   logic        busy, done, error;
   logic [15:0] beat_cnt;

`ifdef STRIDE_RD_GEN_ID_CHECK_EN
   localparam logic ID_EXP = 1'b1;
`else
   localparam logic ID_EXP = 1'b0;
`endif

   always #5 clk = ~clk;

   stride_rd_gen dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
      .req_num(req_num), .cfg_len(cfg_len), .cfg_id(cfg_id),
      .m_ar_valid(m_ar_valid), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
      .m_ar_ready(m_ar_ready), .m_r_valid(m_r_valid), .m_r_last(m_r_last), .m_r_data(m_r_data),
      .m_r_id(m_r_id), .m_r_ready(m_r_ready), .busy(busy), .done(done), .beat_cnt(beat_cnt),
      .error(error)
   );

   typedef struct packed { logic [15:0] addr; logic [7:0] len; logic [7:0] id; } ar_exp_t;
   typedef struct packed { logic [7:0] len; logic [7:0] id; } burst_t;

   ar_exp_t ar_q[$];
   burst_t  pend[$];

   int   n_cmp = 0, n_err = 0;
   int   ar_hs_cnt = 0, done_cnt = 0;
   int   d0 = 0, a0 = 0;
   logic early_done = 1'b0;
   logic r_en = 1'b0, ar_stall = 1'b0, id_bad = 1'b0, sl_clear = 1'b0;
   int   last_at = -1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops the expected AR on every handshake, checks AXI hold rule, counts done pulses.
   initial begin : monitor
      logic        pstall;
      logic [15:0] paddr;
      ar_exp_t     e;
      pstall = 1'b0;
      paddr  = '0;
      forever begin
         @(negedge clk);
         if (pstall) begin
            chk("ar_hold_vld", m_ar_valid, 1);
            chk("ar_hold_addr", m_ar_addr, paddr);
         end
         if (m_ar_valid && m_ar_ready) begin
            ar_hs_cnt++;
            if (ar_q.size() == 0) begin
               chk("ar_unexpected", m_ar_addr, 32'hDEAD_BEEF);
            end else begin
               e = ar_q.pop_front();
               chk("ar_addr", m_ar_addr, e.addr);
               chk("ar_len", m_ar_len, e.len);
               chk("ar_id", m_ar_id, e.id);
            end
         end
         if (done) done_cnt++;
         pstall = m_ar_valid && !m_ar_ready;
         paddr  = m_ar_addr;
      end
   end

   // Read slave: queues accepted bursts and returns their beats in order when r_en is set.
   initial begin : slave
      int     beat;
      logic   ah, rh, rl;
      burst_t nb, tmp;
      beat = 0;
      m_ar_ready = 1'b1;
      m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = '0; m_r_id = '0;
      forever begin
         @(negedge clk);
         ah = m_ar_valid && m_ar_ready;
         rh = m_r_valid && m_r_ready;
         rl = m_r_last;
         nb.len = m_ar_len;
         nb.id  = m_ar_id;
         @(posedge clk);
         #1;
         if (ah) pend.push_back(nb);
         if (rh && pend.size() > 0) begin
            if (rl) begin
               tmp  = pend.pop_front();
               beat = 0;
            end else beat++;
         end
         if (sl_clear) begin
            pend.delete();
            beat = 0;
            sl_clear = 1'b0;
         end
         m_ar_ready = ar_stall ? !m_ar_ready : 1'b1;
         if (r_en && pend.size() > 0) begin
            m_r_valid = 1'b1;
            m_r_data  = 8'(beat);
            m_r_id    = pend[0].id + (id_bad ? 8'd1 : 8'd0);
            m_r_last  = (last_at >= 0) ? (beat == last_at) : (beat == int'(pend[0].len));
         end else begin
            m_r_valid = 1'b0;
            m_r_last  = 1'b0;
         end
      end
   end

   task automatic start_seq(input logic [15:0] b, input logic [15:0] s, input logic [15:0] n,
                            input logic [7:0] l, input logic [7:0] id);
      ar_exp_t e;
      for (int k = 0; k < int'(n); k++) begin
         e.addr = b + 16'(k) * s;
         e.len  = l;
         e.id   = id;
         ar_q.push_back(e);
      end
      d0 = done_cnt;
      a0 = ar_hs_cnt;
      @(posedge clk);
      #1;
      base_addr = b; stride = s; req_num = n; cfg_len = l; cfg_id = id; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("ar_vld_latency", m_ar_valid, (n != 16'd0));
      early_done = done;
   endtask

   task automatic wait_done(input int exp_beats, input logic exp_err);
      logic got;
      got = early_done;
      for (int n = 0; n < 2000 && !got; n++) begin
         @(negedge clk);
         got = done;
      end
      if (!got) chk("done_timeout", 0, 1);
      chk("beat_cnt", beat_cnt, exp_beats);
      chk("error", error, exp_err);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      chk("done_pulses", done_cnt - d0, 1);
      chk("ar_q_empty", ar_q.size(), 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst = 1'b1; start = 1'b0;
      base_addr = '0; stride = '0; req_num = '0; cfg_len = '0; cfg_id = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ar_valid", m_ar_valid, 0);
      chk("rst_r_ready", m_r_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      chk("rst_error", error, 0);
      chk("rst_ar_addr", m_ar_addr, 0);
      r_en = 1'b1;

      // Basic strided sequence, single-beat bursts.
      start_seq(16'h0EEF, 16'd3, 16'd4, 8'd0, 8'd5);
      wait_done(4, 1'b0);

      // Zero requests goes straight to DONE.
      start_seq(16'h1234, 16'd1, 16'd0, 8'd0, 8'd1);
      wait_done(0, 1'b0);

      // Address wrap upward and negative stride.
      start_seq(16'hFFFE, 16'd2, 16'd3, 8'd0, 8'd9);
      wait_done(3, 1'b0);
      start_seq(16'h0010, 16'hFFFD, 16'd3, 8'd0, 8'd9);
      wait_done(3, 1'b0);

      // AR ready toggling: payload must hold through stalls; two-beat bursts.
      ar_stall = 1'b1;
      start_seq(16'h0100, 16'h0010, 16'd3, 8'd1, 8'd2);
      wait_done(6, 1'b0);
      ar_stall = 1'b0;

      // Outstanding limit: R withheld caps AR handshakes at 4.
      r_en = 1'b0;
      start_seq(16'h2000, 16'h0100, 16'd6, 8'd0, 8'd3);
      repeat (10) @(negedge clk);
      chk("outstanding_cap_ars", ar_hs_cnt - a0, 4);
      chk("outstanding_cap_vld", m_ar_valid, 0);
      r_en = 1'b1;
      wait_done(6, 1'b0);
      chk("total_ars", ar_hs_cnt - a0, 6);

      // Early last on beat 2 of a 4-beat burst: sticky error.
      last_at = 2;
      start_seq(16'h3000, 16'd4, 16'd1, 8'd3, 8'd4);
      wait_done(3, 1'b1);
      last_at = -1;
      repeat (5) @(negedge clk);
      chk("error_sticky", error, 1);

      // Wrong R ID: flagged only when the ID check is built in; start also clears old error.
      id_bad = 1'b1;
      start_seq(16'h4000, 16'd8, 16'd2, 8'd1, 8'd5);
      wait_done(4, ID_EXP);
      id_bad = 1'b0;
      start_seq(16'h5000, 16'd1, 16'd2, 8'd0, 8'd5);
      wait_done(2, 1'b0);

      // Reset while draining with two bursts outstanding.
      r_en = 1'b0;
      start_seq(16'h0040, 16'd4, 16'd2, 8'd0, 8'd7);
      repeat (6) @(negedge clk);
      chk("drain_ars", ar_hs_cnt - a0, 2);
      chk("drain_busy", busy, 1);
      chk("drain_ar_vld", m_ar_valid, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_beat_cnt", beat_cnt, 0);
      chk("mid_rst_r_ready", m_r_ready, 0);
      chk("mid_rst_done", done, 0);
      r_en = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_no_beats", beat_cnt, 0);
      chk("post_rst_no_done", done_cnt - d0, 0);
      chk("post_rst_idle", busy, 0);
      r_en = 1'b0;
      sl_clear = 1'b1;
      repeat (2) @(negedge clk);
      chk("final_ar_q_empty", ar_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
